// File: rtl/lsu_mem_initiator.sv
// Load/store unit: turns core byte/half/word accesses into word-indexed memory
// transactions, stalls until memory is ready and flags illegal accesses locally.
module lsu_mem_initiator #(
    parameter int unsigned DATA_MEM_WORDS = 32'd1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_fault_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    localparam logic [2:0] SZ_B  = 3'd0;
    localparam logic [2:0] SZ_H  = 3'd1;
    localparam logic [2:0] SZ_W  = 3'd2;
    localparam logic [2:0] SZ_BU = 3'd4;
    localparam logic [2:0] SZ_HU = 3'd5;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    function automatic logic access_fault(input logic [2:0] size, input logic [31:0] addr);
        logic        bad_s;
        logic [31:0] word_idx_s;
        word_idx_s = {2'b00, addr[31:2]};
        case (size)
            SZ_B, SZ_BU: bad_s = 1'b0;
            SZ_H, SZ_HU: bad_s = addr[0];
            SZ_W:        bad_s = (addr[1:0] != 2'b00);
            default:     bad_s = 1'b1;
        endcase
        if (word_idx_s >= 32'(DATA_MEM_WORDS)) begin
            bad_s = 1'b1;
        end else begin
            bad_s = bad_s;
        end
        return bad_s;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] size, input logic [1:0] off);
        logic [3:0] be_s;
        case (size)
            SZ_B, SZ_BU: be_s = 4'b0001 << off;
            SZ_H, SZ_HU: be_s = off[1] ? 4'b1100 : 4'b0011;
            SZ_W:        be_s = 4'b1111;
            default:     be_s = 4'b0000;
        endcase
        return be_s;
    endfunction

    function automatic logic [31:0] store_wd(input logic [2:0] size, input logic [31:0] wd);
        logic [31:0] rep_s;
        case (size)
            SZ_B, SZ_BU: rep_s = {4{wd[7:0]}};
            SZ_H, SZ_HU: rep_s = {2{wd[15:0]}};
            SZ_W:        rep_s = wd;
            default:     rep_s = 32'd0;
        endcase
        return rep_s;
    endfunction

    function automatic logic [31:0] load_data(input logic [2:0] size, input logic [1:0] off,
                                              input logic [31:0] rd);
        logic [7:0]  byte_s;
        logic [15:0] half_s;
        logic [31:0] ext_s;
        byte_s = 8'(rd >> {off, 3'b000});
        half_s = off[1] ? rd[31:16] : rd[15:0];
        case (size)
            SZ_B:    ext_s = {{24{byte_s[7]}}, byte_s};
            SZ_BU:   ext_s = {24'd0, byte_s};
            SZ_H:    ext_s = {{16{half_s[15]}}, half_s};
            SZ_HU:   ext_s = {16'd0, half_s};
            SZ_W:    ext_s = rd;
            default: ext_s = 32'd0;
        endcase
        return ext_s;
    endfunction

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;

    logic [31:0] core_rd_s;
    logic        core_stall_s;
    logic        core_fault_s;
    logic        mem_req_s;
    logic        mem_we_s;
    logic [3:0]  mem_be_s;
    logic [31:0] mem_addr_s;
    logic [31:0] mem_wd_s;

    // Next-state and output decode; every output is forced low while reset is held.
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        off_d        = off_q;
        core_rd_s    = 32'd0;
        core_stall_s = 1'b0;
        core_fault_s = 1'b0;
        mem_req_s    = 1'b0;
        mem_we_s     = 1'b0;
        mem_be_s     = 4'b0000;
        mem_addr_s   = 32'd0;
        mem_wd_s     = 32'd0;
        if (rst_ni) begin
            case (state_q)
                ST_IDLE: begin
                    if (!core_req_i) begin
                        state_d = ST_IDLE;
                    end else if (access_fault(core_size_i, core_addr_i)) begin
                        core_fault_s = 1'b1;
                    end else begin
                        mem_req_s    = 1'b1;
                        mem_we_s     = core_we_i;
                        mem_addr_s   = {2'b00, core_addr_i[31:2]};
                        core_stall_s = 1'b1;
                        if (core_we_i) begin
                            mem_be_s = store_be(core_size_i, core_addr_i[1:0]);
                            mem_wd_s = store_wd(core_size_i, core_wd_i);
                        end else begin
                            mem_be_s = 4'b1111;
                            mem_wd_s = 32'd0;
                        end
                        we_d    = core_we_i;
                        size_d  = core_size_i;
                        off_d   = core_addr_i[1:0];
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Only latched fields are used here, so core inputs changing mid-access are harmless.
                    if (mem_ready_i) begin
                        state_d   = ST_IDLE;
                        core_rd_s = we_q ? 32'd0 : load_data(size_q, off_q, mem_rd_i);
                    end else begin
                        core_stall_s = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = ST_IDLE;
        end
    end

    // State and latched access fields.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            size_q  <= 3'd0;
            off_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            off_q   <= off_d;
        end
    end

    assign core_rd_o    = core_rd_s;
    assign core_stall_o = core_stall_s;
    assign core_fault_o = core_fault_s;
    assign mem_req_o    = mem_req_s;
    assign mem_we_o     = mem_we_s;
    assign mem_be_o     = mem_be_s;
    assign mem_addr_o   = mem_addr_s;
    assign mem_wd_o     = mem_wd_s;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Scoreboard bench for lsu_mem_initiator: a byte-level reference memory predicts every
// response, a word memory model answers the DUT, and a negedge monitor compares.
module tb_lsu_mem_initiator;

    logic        clk_i;
    logic        rst_ni;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        core_fault_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    lsu_mem_initiator #(.DATA_MEM_WORDS(1024)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_size_i  (core_size_i),
        .core_addr_i  (core_addr_i),
        .core_wd_i    (core_wd_i),
        .core_rd_o    (core_rd_o),
        .core_stall_o (core_stall_o),
        .core_fault_o (core_fault_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wd_o     (mem_wd_o),
        .mem_rd_i     (mem_rd_i),
        .mem_ready_i  (mem_ready_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    typedef struct {
        logic        fault;
        logic        we;
        logic [31:0] rd;
        logic [31:0] maddr;
        logic [31:0] wd;
        logic [3:0]  be;
        int          stalls;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  ref_mem [0:4095];
    logic [31:0] mem     [0:1023];
    logic [31:0] rd_lat;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Word memory answering the DUT; read data only visible while ready is high
    always @(posedge clk_i) begin
        if (rst_ni && mem_req_o) begin
            if (mem_we_o) begin
                for (int k = 0; k < 4; k++) begin
                    if (mem_be_o[k]) mem[mem_addr_o[9:0]][8*k +: 8] <= mem_wd_o[8*k +: 8];
                end
            end else begin
                rd_lat <= mem[mem_addr_o[9:0]];
            end
        end
    end
    assign mem_rd_i = mem_ready_i ? rd_lat : 32'hBAD0_BAD0;

    // Reference model: access rules applied to a flat byte array
    task automatic ref_model(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                             input logic [31:0] data, input int w, output exp_t e);
        int n;
        logic [31:0] val;
        case (sz)
            3'd0, 3'd4: n = 1;
            3'd1, 3'd5: n = 2;
            3'd2:       n = 4;
            default:    n = 0;
        endcase
        e.we    = we;
        e.maddr = addr >> 2;
        e.rd    = 32'd0;
        e.be    = 4'b0000;
        e.wd    = 32'd0;
        e.fault = (n == 0) || ((addr / 4) >= 1024);
        if (n != 0) e.fault = e.fault || ((addr % n) != 0);
        e.stalls = e.fault ? 0 : 1 + w;
        if (!e.fault) begin
            if (we) begin
                for (int i = 0; i < n; i++) begin
                    e.be[(addr % 4) + i] = 1'b1;
                    ref_mem[addr + i] = data[8*i +: 8];
                end
                for (int k = 0; k < 4; k++) e.wd[8*k +: 8] = data[8*(k % n) +: 8];
            end else begin
                e.be = 4'b1111;
                val  = 32'd0;
                for (int i = 0; i < n; i++) val = val | (32'(ref_mem[addr + i]) << (8*i));
                if ((sz == 3'd0 || sz == 3'd1) && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8*n));
                e.rd = val;
            end
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                         input logic [31:0] data);
        core_req_i  = 1'b1;
        core_we_i   = we;
        core_size_i = sz;
        core_addr_i = addr;
        core_wd_i   = data;
        mem_ready_i = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                         input logic [31:0] data, input int w);
        exp_t e;
        ref_model(we, sz, addr, data, w, e);
        exp_q.push_back(e);
        drive(we, sz, addr, data);
        @(posedge clk_i); #1;
        if (!e.fault) begin
            repeat (w) begin
                @(posedge clk_i); #1;
            end
            mem_ready_i = 1'b1;
            @(posedge clk_i); #1;
            mem_ready_i = 1'b0;
        end
    endtask

    task automatic idle();
        core_req_i  = 1'b0;
        core_we_i   = 1'($urandom);
        core_addr_i = $urandom;
        core_wd_i   = $urandom;
        @(posedge clk_i); #1;
    endtask

    task automatic chk_outs_zero(input string nm);
        chk({nm, "_ctl"}, {25'd0, mem_req_o, mem_we_o, mem_be_o, core_stall_o}, 32'd0);
        chk({nm, "_flt"}, {31'd0, core_fault_o}, 32'd0);
        chk({nm, "_rd"}, core_rd_o, 32'd0);
        chk({nm, "_addr"}, mem_addr_o, 32'd0);
        chk({nm, "_wd"}, mem_wd_o, 32'd0);
    endtask

    // Monitor: compares DUT behaviour against the front of the expected queue
    initial begin
        exp_t e;
        int   stall_cnt = 0;
        bit   in_flight = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                if (in_flight && exp_q.size() > 0) void'(exp_q.pop_front());
                in_flight = 1'b0;
                stall_cnt = 0;
            end else begin
                chk("req_and_fault", {31'd0, mem_req_o & core_fault_o}, 32'd0);
                if (!core_req_i) begin
                    chk("idle_ctl", {24'd0, mem_req_o, mem_we_o, mem_be_o, core_stall_o, core_fault_o}, 32'd0);
                    chk("idle_rd", core_rd_o, 32'd0);
                end else begin
                    if (mem_req_o) begin
                        chk("req_pulse", {31'd0, in_flight}, 32'd0);
                        if (exp_q.size() == 0) begin
                            chk("unexpected_req", 32'd1, 32'd0);
                        end else begin
                            e = exp_q[0];
                            chk("mem_we", {31'd0, mem_we_o}, {31'd0, e.we});
                            chk("mem_be", {28'd0, mem_be_o}, {28'd0, e.be});
                            chk("mem_addr", mem_addr_o, e.maddr);
                            chk("mem_wd", mem_wd_o, e.wd);
                        end
                        in_flight = 1'b1;
                    end
                    if (core_stall_o) begin
                        stall_cnt++;
                        chk("busy_fault", {31'd0, core_fault_o}, 32'd0);
                        chk("busy_rd", core_rd_o, 32'd0);
                    end else begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_done", 32'd1, 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("fault", {31'd0, core_fault_o}, {31'd0, e.fault});
                            chk("rd", core_rd_o, e.rd);
                            chk("stalls", 32'(stall_cnt), 32'(e.stalls));
                            chk("fault_noreq", {31'd0, mem_req_o}, 32'd0);
                        end
                        stall_cnt = 0;
                        in_flight = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        logic [31:0] addr;
        logic [2:0]  sz;
        int          pick;
        logic [2:0]  legal_sz [0:4];
        logic [2:0]  bad_sz   [0:2];
        legal_sz = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        bad_sz   = '{3'd3, 3'd6, 3'd7};
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'd0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        rd_lat = 32'd0;
        rst_ni = 1'b0;
        drive(1'b1, 3'd2, 32'h10, 32'h1234_5678);
        #12;
        chk_outs_zero("reset");
        @(posedge clk_i); #1;
        core_req_i = 1'b0;
        rst_ni     = 1'b1;
        @(posedge clk_i); #1;

        issue(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 0);
        issue(1'b0, 3'd2, 32'h10, 32'h0, 0);
        issue(1'b1, 3'd0, 32'h13, 32'h0000_00A5, 0);
        issue(1'b0, 3'd0, 32'h13, 32'h0, 0);
        issue(1'b0, 3'd4, 32'h13, 32'h0, 1);
        issue(1'b1, 3'd1, 32'h22, 32'h0000_8001, 0);
        issue(1'b0, 3'd1, 32'h22, 32'h0, 0);
        issue(1'b0, 3'd5, 32'h22, 32'h0, 2);
        issue(1'b0, 3'd2, 32'h06, 32'h0, 0);
        issue(1'b0, 3'd1, 32'h05, 32'h0, 0);
        issue(1'b0, 3'd2, 32'h1000, 32'h0, 0);
        issue(1'b0, 3'd3, 32'h20, 32'h0, 0);
        issue(1'b0, 3'd2, 32'hFFC, 32'h0, 0);
        issue(1'b0, 3'd2, 32'h10, 32'h0, 3);
        idle();

        // Reset in the middle of a load: response dropped, outputs cleared at once
        ref_model(1'b0, 3'd2, 32'h10, 32'h0, 5, e);
        exp_q.push_back(e);
        drive(1'b0, 3'd2, 32'h10, 32'h0);
        @(posedge clk_i); #1;
        @(negedge clk_i); #2;
        rst_ni = 1'b0;
        #1;
        chk_outs_zero("rst_wait");
        @(posedge clk_i); #1;
        core_req_i = 1'b0;
        @(negedge clk_i);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        issue(1'b0, 3'd2, 32'h10, 32'h0, 0);

        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 15) == 0) addr = 32'($urandom_range(1020, 1030)) * 4 + $urandom_range(0, 3);
            else addr = 32'($urandom_range(0, 15)) * 4 + $urandom_range(0, 3);
            pick = $urandom_range(0, 11);
            if (pick < 10) sz = legal_sz[pick % 5];
            else sz = bad_sz[$urandom_range(0, 2)];
            issue(1'($urandom), sz, addr, $urandom, $urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) idle();
        end
        idle();
        idle();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
